uart_tx_engine: RTL and testbench

//  Parametrised UART transmit engine: serialises words from the TX FIFO onto tx_out, LSB first.

---
 rtl/uart_tx_engine.sv | 151 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops words from the TX FIFO and serialises them LSB first,
// with runtime word length, parity mode, stop bits and line-break generation.
module uart_tx_engine #(
    parameter int MAX_DATA_BITS = 9,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     baud_tick,
    input  logic                     tx_valid,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    output logic                     tx_ready,
    input  logic [3:0]               cfg_data_bits,
    input  logic [2:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic                     cfg_break,
    output logic                     tx_out,
    output logic                     busy,
    output logic                     bit_tick,
    output logic [2:0]               state
);
    localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = $clog2(MAX_DATA_BITS);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_BREAK  = 3'd6,
        S_MAB    = 3'd7
    } state_t;

    state_t                   r_state, w_next;
    logic [OS_W-1:0]          r_ostick;
    logic [IDX_W-1:0]         r_bit_idx;
    logic [MAX_DATA_BITS-1:0] r_data;
    logic [3:0]               r_nbits;
    logic [2:0]               r_parity;
    logic                     r_stop2, r_tx_out, r_bit_tick;

    logic                     w_accept, w_timed, w_bit_end, w_last_bit;
    logic                     w_par_en, w_par_bit, w_tx_next;
    logic [3:0]               w_nbits;
    logic [MAX_DATA_BITS-1:0] w_mask;

    assign tx_ready   = (r_state == S_IDLE) && !cfg_break;
    assign w_accept   = tx_valid && tx_ready;
    // IDLE and BREAK are untimed: ostick stays cleared so the next timed state starts a fresh bit.
    assign w_timed    = !(r_state inside {S_IDLE, S_BREAK});
    assign w_bit_end  = w_timed && baud_tick && (r_ostick == OS_LAST);
    assign w_last_bit = (r_bit_idx == IDX_W'(r_nbits - 4'd1));
    assign w_par_en   = (r_parity >= 3'd1) && (r_parity <= 3'd4);

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_nbits = cfg_data_bits;
        if (cfg_data_bits < 4'd5)
            w_nbits = 4'd5;
        else if (cfg_data_bits > 4'(MAX_DATA_BITS))
            w_nbits = 4'(MAX_DATA_BITS);
        w_mask = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            w_mask[i] = (i < int'(w_nbits));
    end

    always_comb begin
        w_par_bit = 1'b1;
        case (r_parity)
            3'd1:    w_par_bit = ^r_data;
            3'd2:    w_par_bit = ~^r_data;
            3'd4:    w_par_bit = 1'b0;
            default: w_par_bit = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cfg_break) w_next = S_BREAK;
                      else if (tx_valid) w_next = S_START;
            S_START:  if (w_bit_end) w_next = S_DATA;
            S_DATA:   if (w_bit_end && w_last_bit) w_next = w_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (w_bit_end) w_next = S_STOP1;
            S_STOP1:  if (w_bit_end) w_next = r_stop2 ? S_STOP2 : S_IDLE;
            S_STOP2:  if (w_bit_end) w_next = S_IDLE;
            S_BREAK:  if (!cfg_break) w_next = S_MAB;
            S_MAB:    if (w_bit_end) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_data[r_bit_idx];
            S_PARITY: w_tx_next = w_par_bit;
            S_BREAK:  w_tx_next = 1'b0;
            default:  w_tx_next = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: the latched word and config are reset too, so a frame cut short by reset leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ostick   <= '0;
            r_bit_idx  <= '0;
            r_data     <= '0;
            r_nbits    <= 4'd5;
            r_parity   <= 3'd0;
            r_stop2    <= 1'b0;
            r_tx_out   <= 1'b1;
            r_bit_tick <= 1'b0;
        end else begin
            r_tx_out   <= w_tx_next;
            r_bit_tick <= w_bit_end;
            if (!w_timed)
                r_ostick <= '0;
            else if (baud_tick)
                r_ostick <= (r_ostick == OS_LAST) ? '0 : r_ostick + 1'b1;
            if (r_state == S_IDLE)
                r_bit_idx <= '0;
            else if (w_bit_end && (r_state == S_DATA))
                r_bit_idx <= r_bit_idx + 1'b1;
            if (w_accept) begin
                r_data   <= tx_data & w_mask;
                r_nbits  <= w_nbits;
                r_parity <= cfg_parity;
                r_stop2  <= cfg_stop2;
            end
        end
    end

    assign tx_out   = r_tx_out;
    assign bit_tick = r_bit_tick;
    assign busy     = (r_state != S_IDLE);
    assign state    = r_state;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frames are sampled mid-bit and compared with hand-computed patterns.
module tb_uart_tx_engine;
    logic       clk = 1'b0;
    logic       reset, baud_tick, tx_valid, tx_ready;
    logic [8:0] tx_data;
    logic [3:0] cfg_data_bits;
    logic [2:0] cfg_parity, state;
    logic       cfg_stop2, cfg_break, tx_out, busy, bit_tick;

    int tick_div = 1;
    int n_checks = 0, n_pass = 0;
    int n_fticks = 0, n_bticks = 0, n_pops = 0;

    uart_tx_engine #(.MAX_DATA_BITS(9), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .cfg_data_bits(cfg_data_bits),
        .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_break(cfg_break),
        .tx_out(tx_out), .busy(busy), .bit_tick(bit_tick), .state(state)
    );

    initial forever #5 clk = ~clk;

    // Baud tick every tick_div clocks, driven just after the rising edge.
    initial begin
        int cnt;
        cnt = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt = cnt + 1;
            if (cnt >= tick_div) cnt = 0;
            baud_tick = (cnt == 0);
        end
    end

    always @(negedge clk) begin
        if (baud_tick && state >= 3'd1 && state <= 3'd5) n_fticks++;
        if (bit_tick) n_bticks++;
        if (tx_valid && tx_ready) n_pops++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_word();
        int k;
        k = 0;
        tx_valid = 1'b1;
        while (k < 20000) begin
            @(negedge clk);
            if (tx_ready) break;
            k++;
        end
        check("push timeout", k < 20000, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic capture(input int n, output logic [31:0] bits);
        int k;
        bits = '0;
        k = 0;
        while (k < 20000) begin
            @(negedge clk);
            if (!tx_out) break;
            k++;
        end
        check("start bit timeout", k < 20000, 1);
        repeat (8 * tick_div) @(negedge clk);
        bits[0] = tx_out;
        for (int i = 1; i < n; i++) begin
            repeat (16 * tick_div) @(negedge clk);
            bits[i] = tx_out;
        end
    endtask

    task automatic wait_frame_end();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (state >= 3'd1 && state <= 3'd5 && k < 20000);
        check("frame end timeout", k < 20000, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // action: 0 none, 1 change config mid-frame, 2 raise cfg_break mid-frame
    task automatic do_frame(input string tag, input logic [8:0] data, input logic [3:0] nb,
                            input logic [2:0] par, input logic s2, input int flen,
                            input logic [31:0] exp_bits, input int action);
        logic [31:0] got;
        int t0, b0, p0;
        cfg_data_bits = nb; cfg_parity = par; cfg_stop2 = s2; tx_data = data;
        t0 = n_fticks; b0 = n_bticks; p0 = n_pops;
        fork
            push_word();
            capture(flen, got);
            begin
                if (action != 0) begin
                    repeat (60 * tick_div) @(posedge clk);
                    #1;
                    if (action == 1) begin
                        cfg_parity = 3'd2; cfg_stop2 = 1'b1; cfg_data_bits = 4'd5; tx_data = 9'h000;
                    end else begin
                        cfg_break = 1'b1;
                    end
                end
            end
        join
        wait_frame_end();
        check({tag, " bits"}, got, exp_bits);
        check({tag, " ticks"}, n_fticks - t0, flen * 16);
        check({tag, " bit_ticks"}, n_bticks - b0, flen);
        check({tag, " pops"}, n_pops - p0, 1);
    endtask

    task automatic release_break(input string tag);
        int k, mab, rdy;
        k = 0; mab = 0; rdy = 0;
        cfg_break = 1'b0;
        while (k < 2000) begin
            @(negedge clk);
            if (state == 3'd0) break;
            if (tx_ready) rdy++;
            if (state == 3'd7 && baud_tick) mab++;
            k++;
        end
        check({tag, " mab timeout"}, k < 2000, 1);
        check({tag, " mab ticks"}, mab, 16);
        check({tag, " ready in break"}, rdy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got;
        int low, rdy, p0, k;
        reset = 1'b1; tx_valid = 1'b0; tx_data = '0;
        cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0; cfg_break = 1'b0;
        #1;
        check("rst tx_out", tx_out, 1);
        check("rst busy", busy, 0);
        check("rst bit_tick", bit_tick, 0);
        check("rst state", state, 0);
        check("rst tx_ready", tx_ready, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        tick_div = 3;
        do_frame("8N1 A5", 9'h0A5, 4'd8, 3'd0, 1'b0, 10, 32'h34A, 0);
        do_frame("7E2 41", 9'h041, 4'd7, 3'd1, 1'b1, 11, 32'h682, 0);
        tick_div = 1;
        do_frame("9O1 clamp12", 9'h1FF, 4'd12, 3'd2, 1'b0, 12, 32'hBFE, 0);
        do_frame("5E1 clamp3", 9'h0F3, 4'd3, 3'd1, 1'b0, 8, 32'h0E6, 0);
        do_frame("8M1 00", 9'h000, 4'd8, 3'd3, 1'b0, 11, 32'h600, 0);
        do_frame("8S1 FF", 9'h0FF, 4'd8, 3'd4, 1'b0, 11, 32'h5FE, 0);
        tick_div = 2;
        do_frame("cfg change", 9'h0A5, 4'd8, 3'd0, 1'b0, 10, 32'h34A, 1);

        // Break from IDLE, with a word offered in the same cycle the break rises.
        tick_div = 1;
        p0 = n_pops; low = 0; rdy = 0;
        tx_data = 9'h0AA; tx_valid = 1'b1; cfg_break = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_ready) rdy++;
            if (!tx_out) low++;
            if (i == 0) begin
                @(posedge clk);
                #1 tx_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("break state", state, 6);
        cfg_break = 1'b0;
        k = 0;
        while (k < 2000) begin
            @(negedge clk);
            if (state == 3'd0) break;
            if (tx_ready) rdy++;
            if (!tx_out) low++;
            k++;
        end
        check("break idle timeout", k < 2000, 1);
        check("break low clks", low, 500);
        check("break ready", rdy, 0);
        check("break no pop", n_pops - p0, 0);
        @(posedge clk);
        #1 cfg_break = 1'b1;
        @(posedge clk);
        #1 release_break("break2");

        // Break raised mid-frame must not truncate the frame.
        do_frame("break mid", 9'h0A5, 4'd8, 3'd0, 1'b0, 10, 32'h34A, 2);
        check("break mid state", state, 6);
        check("break mid tx_out", tx_out, 0);
        repeat (20) @(posedge clk);
        #1 release_break("break mid");

        // Reset during data bit 3.
        cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0; tx_data = 9'h0A5;
        fork
            push_word();
            begin
                k = 0;
                while (k < 20000) begin
                    @(negedge clk);
                    if (!tx_out) break;
                    k++;
                end
            end
        join
        repeat (72) @(negedge clk);
        check("rst mid pre tx_out", tx_out, 0);
        reset = 1'b1;
        #1;
        check("rst mid tx_out", tx_out, 1);
        check("rst mid busy", busy, 0);
        check("rst mid state", state, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!tx_out || busy) low++;
        end
        check("rst mid no resend", low, 0);
        @(posedge clk);
        #1;
        do_frame("after rst", 9'h03C, 4'd8, 3'd0, 1'b0, 10, 32'h278, 0);

        // Back-to-back words with tx_valid held.
        p0 = n_pops; k = n_fticks;
        cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
        fork
            begin
                logic [8:0] words [3];
                words[0] = 9'h000; words[1] = 9'h0FF; words[2] = 9'h055;
                for (int w = 0; w < 3; w++) begin
                    int j;
                    j = 0;
                    tx_data = words[w];
                    tx_valid = 1'b1;
                    while (j < 20000) begin
                        @(negedge clk);
                        if (tx_ready) break;
                        j++;
                    end
                    check("b2b push timeout", j < 20000, 1);
                    @(posedge clk);
                    #1;
                end
                tx_valid = 1'b0;
            end
            capture(30, got);
        join
        wait_frame_end();
        check("b2b frame0", got[9:0], 32'h200);
        check("b2b frame1", got[19:10], 32'h3FE);
        check("b2b frame2", got[29:20], 32'h2AA);
        check("b2b pops", n_pops - p0, 3);
        check("b2b ticks", n_fticks - k, 480);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
